sram_port_ctrl: RTL and testbench

SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

---
 rtl/sram_pkg.sv | 26 ++
 rtl/sram_rsp_fifo.sv | 62 ++++++
 rtl/sram_port_ctrl.sv | 88 ++++++++
 tb/tb_sram_port_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared configuration helpers for the SRAM port controller.
// Widths are derived here so the controller and its response FIFO always agree.
package sram_pkg;

  localparam int MAX_READ_LAT  = 8;
  localparam int MAX_RSP_DEPTH = 16;

  function automatic int lanes(input int width, input int wordsize);
    return width / wordsize;
  endfunction

  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // The FIFO must hold every read that can be in flight plus one being popped.
  function automatic bit cfg_ok(input int read_lat, input int rsp_depth);
    return (read_lat >= 1) && (read_lat <= MAX_READ_LAT) &&
           (rsp_depth >= read_lat + 1) && (rsp_depth <= MAX_RSP_DEPTH);
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Read-response FIFO; pointers wrap modulo RSP_DEPTH so any depth works.
// Storage is left unreset; only the pointers and occupancy clear.
module sram_rsp_fifo
  import sram_pkg::*;
#(
  parameter int WIDTH     = 512,
  parameter int RSP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int PW = ptr_w(RSP_DEPTH);
  localparam int CW = credit_w(RSP_DEPTH);

  logic [WIDTH-1:0] r_mem [RSP_DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPop;
  logic             w_full;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == PW'(RSP_DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign w_doPop = i_pop && (r_count != '0);
  assign w_full  = (r_count == CW'(RSP_DEPTH));
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_doPop) r_rdPtr <= nextPtr(r_rdPtr);
      case ({i_push, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wrPtr] <= i_data;
  end

  // Upstream credit flow control must make overflow impossible.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(i_push && w_full && !w_doPop));
  end

endmodule

// File: rtl/sram_port_ctrl.sv
// Request/response front end for a synchronous SRAM: posted masked writes,
// pipelined reads with credit-based backpressure into a response FIFO.
module sram_port_ctrl
  import sram_pkg::*;
#(
  parameter int WORDSIZE  = 64,
  parameter int WIDTH     = 512,
  parameter int LOGDEPTH  = 9,
  parameter int READ_LAT  = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_write,
  input  logic [LOGDEPTH-1:0]                req_addr,
  input  logic [WIDTH-1:0]                   req_wdata,
  input  logic [lanes(WIDTH, WORDSIZE)-1:0]  req_wmask,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [WIDTH-1:0]                   rsp_rdata,
  output logic [LOGDEPTH-1:0]                sram_readAddr,
  input  logic [WIDTH-1:0]                   sram_readData,
  output logic [LOGDEPTH-1:0]                sram_writeAddr,
  output logic [WIDTH-1:0]                   sram_writeData,
  output logic [lanes(WIDTH, WORDSIZE)-1:0]  sram_writeEnable
);

  localparam int  CW     = credit_w(RSP_DEPTH);
  localparam bit  CFG_OK = cfg_ok(READ_LAT, RSP_DEPTH);

  logic                w_pop;
  logic                w_readRoom;
  logic                w_readGo;
  logic                w_writeGo;
  logic                w_pipeOut;
  logic [READ_LAT-1:0] r_pipe;
  logic [CW-1:0]       r_credit;
  logic [LOGDEPTH-1:0] r_readAddr;

  assign w_pop      = rsp_valid && rsp_ready;
  // Credit never exceeds RSP_DEPTH, so a same-cycle pop frees exactly one slot.
  assign w_readRoom = (r_credit < CW'(RSP_DEPTH)) || w_pop;
  assign req_ready  = !reset && (req_write || w_readRoom);
  assign w_writeGo  = req_valid && req_ready && req_write;
  assign w_readGo   = req_valid && req_ready && !req_write;

  assign sram_writeAddr   = req_addr;
  assign sram_writeData   = req_wdata;
  assign sram_writeEnable = w_writeGo ? req_wmask : '0;
  assign sram_readAddr    = w_readGo ? req_addr : r_readAddr;
  assign w_pipeOut        = r_pipe[READ_LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe     <= '0;
      r_credit   <= '0;
      r_readAddr <= '0;
    end else begin
      r_pipe <= (r_pipe << 1) | READ_LAT'(w_readGo);
      if (w_readGo) r_readAddr <= req_addr;
      case ({w_readGo, w_pop})
        2'b10:   r_credit <= r_credit + CW'(1);
        2'b01:   r_credit <= r_credit - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (CFG_OK && (r_credit <= CW'(RSP_DEPTH)));
  end

  sram_rsp_fifo #(
    .WIDTH     (WIDTH),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rspFifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_pipeOut),
    .i_data  (sram_readData),
    .i_pop   (w_pop),
    .o_valid (rsp_valid),
    .o_data  (rsp_rdata)
  );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Self-checking bench for sram_port_ctrl: behavioural SRAM, shadow memory and
// an in-order response scoreboard, driven from vector tables and short sequences.
module tb_sram_port_ctrl;

  localparam int WORDSIZE  = 64;
  localparam int WIDTH     = 512;
  localparam int LOGDEPTH  = 9;
  localparam int READ_LAT  = 1;
  localparam int RSP_DEPTH = 4;
  localparam int LANES     = WIDTH / WORDSIZE;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                req_valid, req_ready, req_write;
  logic [LOGDEPTH-1:0] req_addr;
  logic [WIDTH-1:0]    req_wdata;
  logic [LANES-1:0]    req_wmask;
  logic                rsp_valid, rsp_ready;
  logic [WIDTH-1:0]    rsp_rdata;
  logic [LOGDEPTH-1:0] sram_readAddr, sram_writeAddr;
  logic [WIDTH-1:0]    sram_readData, sram_writeData;
  logic [LANES-1:0]    sram_writeEnable;

  always #5 clk = ~clk;

  sram_port_ctrl #(
    .WORDSIZE (WORDSIZE), .WIDTH (WIDTH), .LOGDEPTH (LOGDEPTH),
    .READ_LAT (READ_LAT), .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk (clk), .reset (reset),
    .req_valid (req_valid), .req_ready (req_ready), .req_write (req_write),
    .req_addr (req_addr), .req_wdata (req_wdata), .req_wmask (req_wmask),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
    .sram_readAddr (sram_readAddr), .sram_readData (sram_readData),
    .sram_writeAddr (sram_writeAddr), .sram_writeData (sram_writeData),
    .sram_writeEnable (sram_writeEnable)
  );

  function automatic logic [WIDTH-1:0] mergeLanes(input logic [WIDTH-1:0] old,
                                                  input logic [WIDTH-1:0] data,
                                                  input logic [LANES-1:0] mask);
    logic [WIDTH-1:0] res = old;
    for (int l = 0; l < LANES; l++)
      if (mask[l]) res[l*WORDSIZE +: WORDSIZE] = data[l*WORDSIZE +: WORDSIZE];
    return res;
  endfunction

  // Single-cycle synchronous SRAM (READ_LAT = 1) with per-lane write enables.
  logic [WIDTH-1:0] sramMem [1 << LOGDEPTH];
  logic [WIDTH-1:0] sramRd;
  always @(posedge clk) begin
    sramRd <= sramMem[sram_readAddr];
    if (sram_writeEnable != '0)
      sramMem[sram_writeAddr] <= mergeLanes(sramMem[sram_writeAddr], sram_writeData, sram_writeEnable);
  end
  assign sram_readData = sramRd;

  logic [WIDTH-1:0] shadow [1 << LOGDEPTH];
  logic [WIDTH-1:0] expQ [$];
  int total = 0, bad = 0, cycleNo = 0, popCount = 0;
  int lastPopCycle = 0, lastReadCycle = 0;
  bit lastAccept;

  typedef struct {
    bit                  wr;
    logic [LOGDEPTH-1:0] addr;
    logic [7:0]          fill;
    logic [LANES-1:0]    mask;
    bit                  rspRdy;
    bit                  expReady;
  } vec_t;

  vec_t tableA [$];
  vec_t tableB [$];

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit wr, input logic [LOGDEPTH-1:0] a,
                               input logic [7:0] fill, input logic [LANES-1:0] m, input bit rr);
    req_valid = v;
    req_write = wr;
    req_addr  = a;
    req_wdata = {64{fill}};
    req_wmask = m;
    rsp_ready = rr;
  endtask

  // Called just after a falling edge with inputs set; samples before the next rising edge.
  task automatic stepCycle();
    #2;
    if (rsp_valid && rsp_ready) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected response: got %0h want none", rsp_rdata);
      end else begin
        checkOutput("rsp_rdata", rsp_rdata, expQ.pop_front());
      end
      popCount++;
      lastPopCycle = cycleNo;
    end
    lastAccept = req_valid && req_ready;
    if (lastAccept) begin
      if (req_write) shadow[req_addr] = mergeLanes(shadow[req_addr], req_wdata, req_wmask);
      else begin
        expQ.push_back(shadow[req_addr]);
        lastReadCycle = cycleNo;
      end
    end
    @(negedge clk);
    cycleNo++;
  endtask

  task automatic drain(input int n);
    applyStimulus(1'b0, 1'b0, '0, 8'h00, '0, 1'b1);
    repeat (n) stepCycle();
  endtask

  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(1'b1, v.wr, v.addr, v.fill, v.mask, v.rspRdy);
    #1;
    checkOutput({tag, " req_ready"}, WIDTH'(req_ready), WIDTH'(v.expReady));
    if (v.wr)
      checkOutput({tag, " wen"}, WIDTH'(sram_writeEnable), WIDTH'(v.expReady ? v.mask : '0));
    else begin
      checkOutput({tag, " wen idle"}, WIDTH'(sram_writeEnable), '0);
      if (v.expReady) checkOutput({tag, " rdaddr"}, WIDTH'(sram_readAddr), WIDTH'(v.addr));
    end
    stepCycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int popsBefore, nextAddr, guard;

    tableA.push_back('{1'b1, 9'd5, 8'hAA, 8'hFF, 1'b1, 1'b1});
    tableA.push_back('{1'b0, 9'd5, 8'h00, 8'h00, 1'b1, 1'b1});
    tableA.push_back('{1'b1, 9'd7, 8'h22, 8'hFF, 1'b1, 1'b1});
    tableA.push_back('{1'b1, 9'd7, 8'h11, 8'h01, 1'b1, 1'b1});
    tableA.push_back('{1'b0, 9'd7, 8'h00, 8'h00, 1'b1, 1'b1});
    tableA.push_back('{1'b1, 9'd3, 8'h33, 8'hFF, 1'b1, 1'b1});
    tableA.push_back('{1'b1, 9'd3, 8'h55, 8'h00, 1'b1, 1'b1});
    tableA.push_back('{1'b0, 9'd3, 8'h00, 8'h00, 1'b1, 1'b1});
    tableA.push_back('{1'b1, 9'd9, 8'hF0, 8'hA5, 1'b1, 1'b1});
    tableA.push_back('{1'b0, 9'd9, 8'h00, 8'h00, 1'b1, 1'b1});

    // Consumer stalled: four reads fit the credit, then reads stall but writes pass.
    for (int i = 0; i < 6; i++)
      tableB.push_back('{1'b0, LOGDEPTH'(10 + i), 8'h00, 8'h00, 1'b0, (i < 4)});
    tableB.push_back('{1'b1, 9'd20, 8'h77, 8'hFF, 1'b0, 1'b1});

    applyStimulus(1'b0, 1'b0, '0, 8'h00, '0, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset rsp_valid", WIDTH'(rsp_valid), '0);
    checkOutput("reset rdaddr", WIDTH'(sram_readAddr), '0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 8'h00, '0, 1'b1);
    #1;
    checkOutput("post-reset req_ready", WIDTH'(req_ready), WIDTH'(1));
    checkOutput("post-reset wen", WIDTH'(sram_writeEnable), '0);
    stepCycle();

    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b1, 1'b1, LOGDEPTH'(a), 8'(a * 17 + 1), '1, 1'b1);
      stepCycle();
    end

    foreach (tableA[i]) runVec(tableA[i], $sformatf("A%0d", i));
    drain(6);
    checkOutput("A queue empty", WIDTH'(expQ.size()), '0);

    applyStimulus(1'b1, 1'b1, 9'd5, 8'hAA, '1, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 9'd5, 8'h00, '0, 1'b1);
    stepCycle();
    drain(6);
    checkOutput("read latency", WIDTH'(lastPopCycle - lastReadCycle), WIDTH'(READ_LAT + 1));

    foreach (tableB[i]) runVec(tableB[i], $sformatf("B%0d", i));

    applyStimulus(1'b1, 1'b0, 9'd2, 8'h00, '0, 1'b1);
    #1;
    checkOutput("full+pop read ready", WIDTH'(req_ready), WIDTH'(1));
    stepCycle();
    applyStimulus(1'b1, 1'b0, 9'd3, 8'h00, '0, 1'b0);
    #1;
    checkOutput("credit stays full", WIDTH'(req_ready), '0);
    stepCycle();
    drain(8);
    checkOutput("B queue empty", WIDTH'(expQ.size()), '0);

    popsBefore = popCount;
    nextAddr = 0;
    guard = 0;
    while (nextAddr < 16 && guard < 400) begin
      applyStimulus(1'b1, 1'b0, LOGDEPTH'(nextAddr), 8'h00, '0, 1'($urandom_range(0, 1)));
      stepCycle();
      if (lastAccept) nextAddr++;
      guard++;
    end
    if (guard >= 400) begin
      total++;
      bad++;
      $display("[TB] FAIL burst timeout: got %0d reads accepted want 16", nextAddr);
    end
    drain(10);
    checkOutput("burst responses", WIDTH'(popCount - popsBefore), WIDTH'(16));
    checkOutput("burst queue empty", WIDTH'(expQ.size()), '0);

    applyStimulus(1'b1, 1'b0, 9'd1, 8'h00, '0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 9'd2, 8'h00, '0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, '0, 8'h00, '0, 1'b0);
    #1;
    checkOutput("pre-reset rsp_valid", WIDTH'(rsp_valid), WIDTH'(1));
    reset = 1'b1;
    #1;
    checkOutput("async reset rsp_valid", WIDTH'(rsp_valid), '0);
    checkOutput("async reset rdaddr", WIDTH'(sram_readAddr), '0);
    expQ.delete();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 8'h00, '0, 1'b1);
    #1;
    checkOutput("reset release req_ready", WIDTH'(req_ready), WIDTH'(1));
    popsBefore = popCount;
    stepCycle();
    drain(8);
    checkOutput("no stale responses", WIDTH'(popCount - popsBefore), '0);

    applyStimulus(1'b1, 1'b0, 9'd4, 8'h00, '0, 1'b1);
    stepCycle();
    drain(6);
    checkOutput("post-reset read", WIDTH'(popCount - popsBefore), WIDTH'(1));
    checkOutput("final queue empty", WIDTH'(expQ.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
